// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one shared ripple-carry adder reused for WIDTH steps.
// Optional macro ZERO_BYPASS_EN lets a zero operand skip the RUN phase and finish in one cycle.

module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [4:0] carry;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry[4];

endmodule

module seq_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  m;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  q;
    logic              c;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  sum;
    logic              c_add;
    logic              last_step;

    assign addend    = q[0] ? m : '0;
    assign last_step = (cnt == CW'(WIDTH - 1));

    // C is cleared by every shift, so the adder's carry-in is always zero.
    if (WIDTH == 4) begin : g_rca4
        rca_4bit u_rca (
            .a         (a),
            .b         (addend),
            .carry_in  (c),
            .sum       (sum),
            .carry_out (c_add)
        );
    end else begin : g_rcan
        logic [WIDTH:0] carry;
        assign carry[0] = c;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sum[i]       = a[i] ^ addend[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & addend[i]) | (carry[i] & (a[i] ^ addend[i]));
        end
        assign c_add = carry[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            m     <= '0;
            a     <= '0;
            q     <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= X;
                        a   <= '0;
                        c   <= 1'b0;
                        cnt <= '0;
`ifdef ZERO_BYPASS_EN
                        if ((X == '0) || (Y == '0)) begin
                            q     <= '0;
                            P     <= '0;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            q     <= Y;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`else
                        q     <= Y;
                        busy  <= 1'b1;
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    // Add then shift {C,A,Q} right by one, keeping the adder's carry.
                    a   <= {c_add, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    c   <= 1'b0;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        P     <= {c_add, sum, q[WIDTH-1:1]};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed bench for seq_mul_ctrl: cycle-level product/latency model plus hand-computed checks.
// Honours ZERO_BYPASS_EN the same way the design does.

module tb_seq_mul_ctrl;

    localparam int W = 4;

`ifdef ZERO_BYPASS_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic           clk;
    logic           rst_b;
    logic           start;
    logic [W-1:0]   X;
    logic [W-1:0]   Y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int total = 0;
    int bad   = 0;

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining busy cycles after acceptance; the last one is the done cycle.
    int             m_left = 0;
    int             m_pend = 0;
    logic [2*W-1:0] m_p    = '0;

    always @(negedge rst_b) begin
        m_left = 0;
        m_p    = '0;
    end

    always @(posedge clk) begin
        if (!rst_b) begin
            m_left = 0;
            m_p    = '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend = int'(X) * int'(Y);
                m_left = (ZB && (X == 0 || Y == 0)) ? 1 : W + 1;
            end
        end else begin
            m_left--;
        end
        if (m_left == 1) m_p = (2*W)'(m_pend);
        #1;
        total++;
        if (busy !== (m_left != 0)) begin
            bad++;
            $display("[TB] FAIL model_busy t=%0t got=%b want=%b", $time, busy, m_left != 0);
        end
        total++;
        if (done !== (m_left == 1)) begin
            bad++;
            $display("[TB] FAIL model_done t=%0t got=%b want=%b", $time, done, m_left == 1);
        end
        total++;
        if (P !== m_p) begin
            bad++;
            $display("[TB] FAIL model_p t=%0t got=%h want=%h", $time, P, m_p);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        X     = x;
        Y     = y;
        @(posedge clk);
        #2;
        start = 1'b0;
        X     = W'($urandom);
        Y     = W'($urandom);
    endtask

    task automatic waitDone(input int budget, output bit seen, output int lat);
        seen = 1'b0;
        lat  = 1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    task automatic runProduct(input logic [W-1:0] x, input logic [W-1:0] y,
                              input int exp_p, input int exp_lat, input string name);
        bit seen;
        int lat;
        applyStimulus(x, y);
        waitDone(20, seen, lat);
        checkOutput({name, "_seen"}, int'(seen), 1);
        checkOutput({name, "_lat"}, lat, exp_lat);
        checkOutput({name, "_p"}, int'(P), exp_p);
        @(posedge clk);
        #2;
        checkOutput({name, "_idle_busy"}, int'(busy), 0);
        checkOutput({name, "_hold_p"}, int'(P), exp_p);
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            if (done) n++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit seen;
        int lat;
        int n;
        int first_cyc;
        int second_cyc;
        int cyc;

        rst_b = 1'b0;
        start = 1'b0;
        X     = '0;
        Y     = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            checkOutput("reset_p", int'(P), 0);
            checkOutput("reset_busy", int'(busy), 0);
            checkOutput("reset_done", int'(done), 0);
        end

        runProduct(4'd13, 4'd11, 8'h8F, 5, "p13x11");
        runProduct(4'd15, 4'd15, 8'hE1, 5, "p15x15");
        runProduct(4'd1,  4'd1,  8'h01, 5, "p1x1");
        runProduct(4'd8,  4'd2,  8'h10, 5, "p8x2");

        // start held high: products must come out WIDTH+2 cycles apart
        @(negedge clk);
        start      = 1'b1;
        X          = 4'd15;
        Y          = 4'd15;
        first_cyc  = -1;
        second_cyc = -1;
        cyc        = 0;
        for (int i = 0; i < 30 && second_cyc < 0; i++) begin
            @(posedge clk);
            #2;
            cyc++;
            if (done) begin
                if (first_cyc < 0) first_cyc = cyc;
                else second_cyc = cyc;
            end
        end
        start = 1'b0;
        checkOutput("b2b_second_seen", int'(second_cyc > 0), 1);
        checkOutput("b2b_gap", second_cyc - first_cyc, W + 2);
        checkOutput("b2b_p", int'(P), 8'hE1);
        countDones(4, n);

        // second request while busy must be ignored
        applyStimulus(4'd6, 4'd7);
        @(posedge clk);
        #2;
        start = 1'b1;
        X     = 4'd3;
        Y     = 4'd3;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitDone(20, seen, lat);
        checkOutput("ign_seen", int'(seen), 1);
        checkOutput("ign_p", int'(P), 8'h2A);
        countDones(10, n);
        checkOutput("ign_no_second_done", n, 0);

        // reset in the middle of RUN discards the product
        applyStimulus(4'd9, 4'd9);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_p", int'(P), 0);
        @(negedge clk);
        rst_b = 1'b1;
        countDones(8, n);
        checkOutput("midrst_no_done", n, 0);
        checkOutput("midrst_p_after", int'(P), 0);
        runProduct(4'd2, 4'd5, 8'h0A, 5, "p2x5");

        runProduct(4'd0, 4'd9, 8'h00, ZB ? 1 : 5, "p0x9");
        runProduct(4'd7, 4'd0, 8'h00, ZB ? 1 : 5, "p7x0");
        runProduct(4'd3, 4'd5, 8'h0F, 5, "p3x5");

        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
